// File: rtl/telemetry_arbiter.sv
// Round-robin arbiter sharing one ready/valid telemetry link among trigger/request/valid producers.
// Each captured word is tagged with the index of the source that supplied it.
module telemetry_arbiter #(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned ID_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                     clk_128MHz,
  input  logic                     rst_128MHz,
  input  logic [NUM_SOURCES-1:0]   src_trigger,
  output logic [NUM_SOURCES-1:0]   src_request,
  input  logic [32*NUM_SOURCES-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]   src_data_valid,
  output logic [31:0]              link_data,
  output logic [ID_W-1:0]          link_tag,
  output logic                     link_valid,
  input  logic                     link_ready,
  output logic [15:0]              drop_count,
  output logic [15:0]              timeout_count
);

  typedef enum logic [1:0] {StIdle, StRequest, StWaitData, StSend} state_e;

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [7:0]             timer_q, timer_d;
  logic [NUM_SOURCES-1:0] request_q, request_d;
  logic [31:0]            data_q, data_d;
  logic [ID_W-1:0]        tag_q, tag_d;
  logic                   valid_q, valid_d;
  logic [15:0]            drop_q, drop_d;
  logic [15:0]            tmo_q, tmo_d;

  logic                   found;
  logic [ID_W-1:0]        pick;
  logic [NUM_SOURCES-1:0] pick_oh, grant_oh, clear_oh, drops;
  logic [31:0]            sel_data;
  logic                   sel_valid;
  logic [4:0]             drop_n;
  logic [16:0]            drop_sum;

  // Search upward from last+1 so the most recently served source has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= int'(NUM_SOURCES); k++) begin
      int idx;
      idx = (int'(last_q) + k) % int'(NUM_SOURCES);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    pick_oh   = '0;
    grant_oh  = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < int'(NUM_SOURCES); i++) begin
      pick_oh[i]  = (pick == ID_W'(i));
      grant_oh[i] = (grant_q == ID_W'(i));
      if (grant_q == ID_W'(i)) begin
        sel_data  = src_data[32*i +: 32];
        sel_valid = src_data_valid[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    timer_d   = timer_q;
    request_d = '0;
    data_d    = data_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    tmo_d     = tmo_q;
    clear_oh  = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d   = pick;
          last_d    = pick;
          request_d = pick_oh;
          state_d   = StRequest;
        end
      end
      StRequest: begin
        clear_oh = grant_oh;
        timer_d  = '0;
        state_d  = StWaitData;
      end
      StWaitData: begin
        if (sel_valid) begin
          data_d  = sel_data;
          tag_d   = grant_q;
          valid_d = 1'b1;
          state_d = StSend;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StSend: begin
        if (link_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A trigger coinciding with the grant clear re-arms the source and is not a drop.
  always_comb begin
    pending_d = (pending_q & ~clear_oh) | src_trigger;
    drops     = src_trigger & pending_q & ~clear_oh;
    drop_n    = '0;
    for (int i = 0; i < int'(NUM_SOURCES); i++) drop_n = drop_n + 5'(drops[i]);
    drop_sum  = {1'b0, drop_q} + 17'(drop_n);
    drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_128MHz) begin
    if (rst_128MHz) begin
      state_q   <= StIdle;
      pending_q <= '0;
      last_q    <= ID_W'(NUM_SOURCES - 1);
      grant_q   <= '0;
      timer_q   <= '0;
      request_q <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      request_q <= request_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      tmo_q     <= tmo_d;
    end
  end

  assign src_request   = request_q;
  assign link_data     = data_q;
  assign link_tag      = tag_q;
  assign link_valid    = valid_q;
  assign drop_count    = drop_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_telemetry_arbiter.sv
// Directed bench for telemetry_arbiter: grant order, backpressure, timeout, drops and reset.
// Sources answer one cycle after their request when enabled in resp_mask.
module tb_telemetry_arbiter;

  logic        clk_128MHz = 1'b0;
  logic        rst_128MHz;
  logic [3:0]  src_trigger;
  logic [3:0]  src_request;
  logic [127:0] src_data;
  logic [3:0]  src_data_valid;
  logic [31:0] link_data;
  logic [1:0]  link_tag;
  logic        link_valid;
  logic        link_ready;
  logic [15:0] drop_count;
  logic [15:0] timeout_count;

  logic [3:0]  req_seen;
  logic [3:0]  resp_mask;
  int          errors = 0;
  int          checks = 0;

  telemetry_arbiter #(.NUM_SOURCES(4), .TIMEOUT(15), .ID_W(2)) dut (
    .clk_128MHz    (clk_128MHz),
    .rst_128MHz    (rst_128MHz),
    .src_trigger   (src_trigger),
    .src_request   (src_request),
    .src_data      (src_data),
    .src_data_valid(src_data_valid),
    .link_data     (link_data),
    .link_tag      (link_tag),
    .link_valid    (link_valid),
    .link_ready    (link_ready),
    .drop_count    (drop_count),
    .timeout_count (timeout_count)
  );

  always #4 clk_128MHz = ~clk_128MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; triggers are single-cycle pulses.
  task automatic tick();
    @(negedge clk_128MHz);
    src_trigger    = '0;
    src_data_valid = req_seen & resp_mask;
    req_seen       = src_request;
  endtask

  task automatic wait_req(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (src_request == 4'b0 && n < 12);
    chk(tag, 32'(src_request), 32'(exp));
  endtask

  initial begin
    int good;
    int lv_seen;
    rst_128MHz     = 1'b1;
    src_trigger    = '0;
    src_data_valid = '0;
    src_data       = {32'h0000_0455, 32'h0000_0355, 32'h0000_0255, 32'h0000_0155};
    link_ready     = 1'b1;
    req_seen       = '0;
    resp_mask      = 4'b1111;

    tick();
    tick();
    chk("rst_request", 32'(src_request), 32'h0);
    chk("rst_valid", 32'(link_valid), 32'h0);
    chk("rst_data", link_data, 32'h0);
    chk("rst_tag", 32'(link_tag), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    chk("rst_timeout", 32'(timeout_count), 32'h0);
    rst_128MHz = 1'b0;

    // Single source, uncontended latency
    src_trigger = 4'b0001;
    tick();
    chk("single_req_early", 32'(src_request), 32'h0);
    tick();
    chk("single_req", 32'(src_request), 32'h1);
    tick();
    chk("single_req_onecycle", 32'(src_request), 32'h0);
    chk("single_valid_early", 32'(link_valid), 32'h0);
    tick();
    chk("single_valid", 32'(link_valid), 32'h1);
    chk("single_data", link_data, 32'h0000_0155);
    chk("single_tag", 32'(link_tag), 32'h0);
    tick();
    chk("single_valid_fall", 32'(link_valid), 32'h0);

    // Fairness after reset
    rst_128MHz = 1'b1;
    tick();
    rst_128MHz = 1'b0;
    src_trigger = 4'b1111;
    wait_req("fair_g0", 4'b0001);
    wait_req("fair_g1", 4'b0010);
    wait_req("fair_g2", 4'b0100);
    wait_req("fair_g3", 4'b1000);
    src_trigger = 4'b0101;
    wait_req("fair_g4", 4'b0001);
    wait_req("fair_g5", 4'b0100);
    chk("fair_nodrop", 32'(drop_count), 32'h0);
    tick(); tick(); tick(); tick();

    // Backpressure
    link_ready  = 1'b0;
    src_trigger = 4'b0100;
    wait_req("bp_req", 4'b0100);
    tick();
    tick();
    chk("bp_valid", 32'(link_valid), 32'h1);
    src_trigger = 4'b0010;
    good = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (link_valid === 1'b1 && link_data === 32'h0000_0355 && link_tag === 2'd2 &&
          src_request === 4'b0) good++;
    end
    chk("bp_hold_cycles", 32'(good), 32'd20);
    link_ready = 1'b1;
    tick();
    chk("bp_accept_once", 32'(link_valid), 32'h0);
    wait_req("bp_next_req", 4'b0010);
    tick();
    tick();
    chk("bp_next_valid", 32'(link_valid), 32'h1);
    chk("bp_next_tag", 32'(link_tag), 32'h1);
    chk("bp_next_data", link_data, 32'h0000_0255);
    tick();
    chk("bp_next_fall", 32'(link_valid), 32'h0);

    // Timeout: source 3 never answers
    resp_mask   = 4'b0000;
    src_trigger = 4'b1000;
    wait_req("to_req", 4'b1000);
    lv_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (link_valid !== 1'b0) lv_seen++;
    end
    chk("to_count_before", 32'(timeout_count), 32'h0);
    tick();
    chk("to_count_after", 32'(timeout_count), 32'h1);
    chk("to_no_valid", 32'(lv_seen + int'(link_valid)), 32'h0);
    resp_mask = 4'b1111;

    // Drop: source 1 triggered twice before its grant
    src_trigger = 4'b0010;
    tick();
    src_trigger = 4'b0010;
    tick();
    chk("drop_req", 32'(src_request), 32'h2);
    chk("drop_count", 32'(drop_count), 32'h1);
    // Trigger in the REQUEST cycle re-arms source 1 without a drop
    src_trigger = 4'b0010;
    wait_req("collide_regrant", 4'b0010);
    chk("collide_nodrop", 32'(drop_count), 32'h1);
    tick(); tick(); tick(); tick();

    // Reset while a word is presented
    link_ready  = 1'b0;
    src_trigger = 4'b0100;
    wait_req("rs_req", 4'b0100);
    tick();
    tick();
    chk("rs_valid_pre", 32'(link_valid), 32'h1);
    src_trigger = 4'b1000;
    tick();
    rst_128MHz = 1'b1;
    tick();
    chk("rs_request", 32'(src_request), 32'h0);
    chk("rs_valid", 32'(link_valid), 32'h0);
    chk("rs_data", link_data, 32'h0);
    chk("rs_tag", 32'(link_tag), 32'h0);
    chk("rs_drop", 32'(drop_count), 32'h0);
    chk("rs_timeout", 32'(timeout_count), 32'h0);
    rst_128MHz = 1'b0;
    link_ready = 1'b1;
    good = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (src_request !== 4'b0) good++;
    end
    chk("rs_pending_cleared", 32'(good), 32'h0);
    src_trigger = 4'b1111;
    wait_req("rs_first_grant", 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/telemetry_arbiter.md
# telemetry_arbiter

Round-robin scheduler that shares one outbound telemetry link among `NUM_SOURCES` telemetry producers. Each producer uses the trigger/request/data-valid handshake: it pulses a trigger when a sample is ready, the arbiter sends a one-cycle request, and the producer answers with data and valid. The arbiter tags each captured word with its source index and presents it on a ready/valid link port. It sits between the telemetry producers, such as test counters and status monitors, and the link framer.

## Interface
Parameters:
- `NUM_SOURCES`, default 4, number of producers, range 2..16.
- `TIMEOUT`, default 15, number of WAIT_DATA cycles without valid before the grant is abandoned, range 1..255.
- `ID_W`, default 2, tag width, equal to clog2(NUM_SOURCES) and at least 1.

Ports:
- `clk_128MHz` in 1: single clock; every port is synchronous to it.
- `rst_128MHz` in 1: synchronous, active-high reset.
- `src_trigger` in NUM_SOURCES: per-source pulse meaning "sample ready".
- `src_request` out NUM_SOURCES: one-hot, one-cycle fetch strobe.
- `src_data` in 32*NUM_SOURCES: source i occupies bits [32i+31:32i].
- `src_data_valid` in NUM_SOURCES: source data-valid response.
- `link_data` out 32: captured word.
- `link_tag` out ID_W: index of the source that supplied `link_data`.
- `link_valid` out 1: word available on the link port.
- `link_ready` in 1: downstream accepts the word.
- `drop_count` out 16: triggers lost because that source already had a trigger pending; saturates at 16'hFFFF.
- `timeout_count` out 16: grants abandoned by timeout; saturates at 16'hFFFF.

## Operation
- `pending[NUM_SOURCES]` register:
  - Set by `src_trigger[i]`.
  - Cleared in the REQUEST cycle of a grant to i.
  - A trigger and a clear for the same i in the same cycle leave the bit set; the set wins.
  - `src_trigger[i]` while `pending[i]` is already set, and no clear of i that cycle, increments `drop_count`.
- FSM states:
  - IDLE:
    - If any `pending` bit is set, grant the first set index searching upward from `last+1` modulo NUM_SOURCES.
    - Set `last` to the granted index and go to REQUEST.
    - Otherwise stay in IDLE.
  - REQUEST:
    - `src_request[g]` is high for exactly this cycle; all other `src_request` bits are low.
    - Clear `pending[g]`, reset the timer to 0, go to WAIT_DATA.
  - WAIT_DATA:
    - If `src_data_valid[g]` is high: capture `src_data[g]` into `link_data`, put g on `link_tag`, go to SEND.
    - Otherwise, if the timer equals TIMEOUT-1: increment `timeout_count`, go to IDLE, and drop the sample.
    - Otherwise increment the timer.
  - SEND: `link_valid`=1 with data and tag held stable; on `link_ready`=1, go to IDLE.
- `src_data_valid` from any non-granted source, or in any state other than WAIT_DATA, is ignored.
- Counters saturate and never wrap.
- Only the reset clears `drop_count` and `timeout_count`.
- Reset in any state, including mid-transfer:
  - Next state is IDLE, `pending`=0, `last`=NUM_SOURCES-1 (so source 0 has first priority).
  - `src_request`=0, `link_valid`=0, `link_data`=0, `link_tag`=0, both counters 0.
  - A word presented but not yet accepted is discarded.

## Timing
- All outputs are registered.
- Reset values: every output 0.
- Uncontended latency:
  - Trigger sampled at edge t.
  - `src_request` high in cycle t+2.
  - A source that answers one cycle after the request drives valid in t+3.
  - `link_valid` rises in cycle t+4.
- Acceptance: a word is accepted on the edge where `link_valid` and `link_ready` are both 1.
- Minimum back-to-back grant spacing: 4 cycles, covering IDLE, REQUEST, WAIT_DATA and SEND with `link_ready` tied high.
- Timeout: with no valid, the FSM leaves WAIT_DATA after exactly TIMEOUT cycles in that state.
- `link_valid` deassertion: `link_valid` falls in the cycle after acceptance.
- `link_valid` never deasserts before acceptance.

## Test plan
- Single source: pulse `src_trigger[0]`; the source returns 32'h0000_0155 one cycle after its request. Required: `src_request`=4'b0001 for one cycle; `link_valid`=1 four cycles after the trigger; data 32'h155; tag 0.
- Fairness: hold all four triggers pending simultaneously after reset. Required: grant order 0,1,2,3. Re-trigger 0 and 2 before the last grant completes; required next grants 0,2.
- Backpressure: hold `link_ready`=0 for 20 cycles. Required: `link_valid` stays 1 with data and tag stable and no further `src_request`; on release, the word is accepted once.
- Timeout: the granted source never asserts valid, TIMEOUT=15. Required: return to IDLE after 15 WAIT_DATA cycles; `timeout_count`=1; no `link_valid`.
- Drops and collisions:
  - Trigger source 1 twice before it is granted. Required: `drop_count`=1.
  - Trigger source 1 in its REQUEST cycle. Required: `pending[1]` stays set and source 1 is granted again.
- Reset mid-SEND: assert `rst_128MHz` while `link_valid`=1. Required: next cycle all outputs 0; after release, the first grant goes to source 0.
